// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache with blocking multi-word refill.
// Define ICACHE_LRU_EN for true-LRU victim selection; default is per-set round-robin.
module icache_assoc #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);
  localparam int WO = $clog2(BLKWORDS);
  localparam int IX = $clog2(SETS);
  localparam int TW = 30 - WO - IX;
  localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW = (BLKWORDS > 1) ? WO : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WB-1:0]     vic_q, vic_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [TW-1:0]     tag_q   [SETS][WAYS];
  logic [31:0]       data_q  [SETS][WAYS][BLKWORDS];

  logic [IX-1:0]     set_idx, fill_set;
  logic [TW-1:0]     tag_in, fill_tag;
  logic [CW-1:0]     woff;
  logic              lookup, hit_any, accept, last, fill_done;
  logic [WB-1:0]     hit_way, victim;

  assign set_idx  = IX'(imemaddr >> (2 + WO));
  assign tag_in   = TW'(imemaddr >> (2 + WO + IX));
  assign woff     = CW'((imemaddr >> 2) % BLKWORDS);
  assign fill_set = IX'(base_q >> (2 + WO));
  assign fill_tag = TW'(base_q >> (2 + WO + IX));

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
        hit_any = 1'b1;
        hit_way = WB'(w);
      end
  end

  // Lookups are suppressed while flushing so a flush cycle never hits or starts a fill.
  assign lookup    = (state_q == IDLE) && imemREN && !flush;
  assign ihit      = lookup && hit_any;
  assign imemload  = ihit ? data_q[set_idx][hit_way][woff] : '0;
  assign iREN      = (state_q == FILL) && !flush;
  assign iaddr     = (state_q == FILL) ? base_q + (32'(cnt_q) << 2) : '0;
  assign accept    = iREN && !iwait;
  assign last      = (cnt_q == CW'(BLKWORDS - 1));
  assign fill_done = accept && last;

`ifdef ICACHE_LRU_EN
  logic [WB-1:0] age_q [SETS][WAYS];
  logic          touch;
  logic [IX-1:0] touch_set;
  logic [WB-1:0] touch_way;
  assign touch     = ihit || fill_done;
  assign touch_set = ihit ? set_idx : fill_set;
  assign touch_way = ihit ? hit_way : vic_q;
`else
  logic [WB-1:0] rr_q [SETS];
`endif

  always_comb begin
    logic found;
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (!found && !valid_q[set_idx][w]) begin
        found  = 1'b1;
        victim = WB'(w);
      end
    if (!found) begin
`ifdef ICACHE_LRU_EN
      for (int w = 1; w < WAYS; w++)
        if (age_q[set_idx][w] > age_q[set_idx][victim]) victim = WB'(w);
`else
      victim = rr_q[set_idx];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    vic_d   = vic_q;
    case (state_q)
      IDLE: if (lookup && !hit_any) begin
        state_d = FILL;
        base_d  = imemaddr & ~32'(BLKWORDS * 4 - 1);
        cnt_d   = '0;
        vic_d   = victim;
      end
      FILL: if (flush) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (accept) begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      vic_q   <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      vic_q   <= vic_d;
      if (flush)
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      else if (fill_done)
        valid_q[fill_set][vic_q] <= 1'b1;
    end
  end

  // Line payload needs no reset: valid bits gate every use of it.
  always_ff @(posedge CLK) begin
    if (accept) begin
      data_q[fill_set][vic_q][cnt_q] <= iload;
      if (last) tag_q[fill_set][vic_q] <= fill_tag;
    end
  end

`ifdef ICACHE_LRU_EN
  // Ties count as younger so the all-zero reset ages settle into a proper ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++)
        if (WB'(w) == touch_way)
          age_q[touch_set][w] <= '0;
        else if (age_q[touch_set][w] <= age_q[touch_set][touch_way] &&
                 age_q[touch_set][w] != WB'(WAYS - 1))
          age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
    end
  end
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (fill_done) begin
      rr_q[fill_set] <= WB'((int'(rr_q[fill_set]) + 1) % WAYS);
    end
  end
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: fetch scoreboard plus an expected-refill-address queue.
module tb_icache_assoc;
  logic        CLK = 1'b0;
  logic        RST, imemREN, flush, iwait, ihit, iREN;
  logic [31:0] imemaddr, imemload, iaddr, iload;

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int wcnt   = 0;
  int acc    = 0;
  logic [31:0] exp_addr [$];
  logic [31:0] rd_q [$];

  icache_assoc dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait)
  );

  always #5 CLK = ~CLK;

  // Memory image: 0x40 -> AAAA0001, 0x44 -> AAAA0002, ...
  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'hAAAA0000 + ((a - 32'h3C) >> 2);
  endfunction

  assign iload = mw(iaddr);
  assign iwait = iREN && (wcnt < wait_n);
  always @(posedge CLK) wcnt <= (iREN && wcnt < wait_n) ? wcnt + 1 : 0;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    if (iREN === 1'b1 && iwait === 1'b0) begin
      acc++;
      chk("accept expected", 32'(exp_addr.size() > 0), 32'd1);
      if (exp_addr.size() > 0) chk("refill iaddr", iaddr, exp_addr.pop_front());
    end
  end

  task automatic push_blk(input logic [31:0] a);
    exp_addr.push_back(a);
    exp_addr.push_back(a + 32'd4);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic fetch(input logic [31:0] a, input int lat, input string nm);
    int n;
    bit got;
    rd_q.push_back(mw(a));
    imemaddr = a;
    imemREN  = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n <= 40) begin
      @(negedge CLK);
      if (ihit === 1'b1) got = 1'b1;
      else begin
        @(posedge CLK); #1;
        n++;
      end
    end
    chk({nm, " hit seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, " data"}, imemload, rd_q.pop_front());
      chk({nm, " latency"}, n, lat);
      chk({nm, " iREN at hit"}, 32'(iREN), 32'd0);
    end else void'(rd_q.pop_front());
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    int a0;
    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b0;
    #3;
    chk("reset ihit", 32'(ihit), 32'd0);
    chk("reset iREN", 32'(iREN), 32'd0);
    chk("reset iaddr", iaddr, 32'd0);
    chk("reset imemload", imemload, 32'd0);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    RST = 1'b0;

    // cold miss then same-block hit
    push_blk(32'h40);
    fetch(32'h40, 3, "cold 40");
    fetch(32'h44, 0, "hit 44");

    // replacement in set 0
    push_blk(32'h80);
    fetch(32'h80, 3, "fill 80");
    fetch(32'h40, 0, "touch 40");
    push_blk(32'hC0);
    fetch(32'hC0, 3, "fill C0");
`ifdef ICACHE_LRU_EN
    fetch(32'h40, 0, "lru keep 40");
    push_blk(32'h80);
    fetch(32'h80, 3, "lru evicted 80");
`else
    fetch(32'h80, 0, "rr keep 80");
    push_blk(32'h40);
    fetch(32'h40, 3, "rr evicted 40");
`endif

    // slow memory: 3 wait cycles per word
    do_reset();
    wait_n = 3;
    push_blk(32'h40);
    fetch(32'h40, 9, "slow 40");
    wait_n = 0;

    // flush on first FILL cycle
    imemaddr = 32'h80; imemREN = 1'b1;
    @(negedge CLK);
    chk("miss ihit", 32'(ihit), 32'd0);
    chk("miss imemload", imemload, 32'd0);
    @(posedge CLK); #1;
    flush = 1'b1;
    @(negedge CLK);
    chk("flush iREN", 32'(iREN), 32'd0);
    @(posedge CLK); #1;
    flush = 1'b0; imemREN = 1'b0;
    push_blk(32'h40);
    fetch(32'h40, 3, "post flush 40");

    // request dropped after the first accepted word
    push_blk(32'h80);
    a0 = acc;
    imemaddr = 32'h80; imemREN = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    imemREN = 1'b0; imemaddr = 32'h200;
    repeat (3) begin @(posedge CLK); #1; end
    chk("drop accepts", 32'(acc - a0), 32'd2);
    chk("drop iREN idle", 32'(iREN), 32'd0);
    a0 = acc;
    fetch(32'h84, 0, "drop hit 84");
    chk("drop hit no refill", 32'(acc - a0), 32'd0);

    // reset in the middle of a fill
    imemaddr = 32'h100; imemREN = 1'b1;
    @(posedge CLK); #1;
    chk("pre-reset iREN", 32'(iREN), 32'd1);
    RST = 1'b1;
    #1;
    chk("midfill rst ihit", 32'(ihit), 32'd0);
    chk("midfill rst iREN", 32'(iREN), 32'd0);
    chk("midfill rst iaddr", iaddr, 32'd0);
    imemREN = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    push_blk(32'h100);
    fetch(32'h100, 3, "reread 100");

    chk("refill queue drained", 32'(exp_addr.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
